m16_fill_sched: RTL and testbench
=================================

M16_FILL_SCHED -- requirements
Module: m16_fill_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63: cycles an owner slot waits for valid before filler is written.
REQ-002 SHALL have parameter FILLER, default 12'hFFF: word written on timeout.
REQ-003 SHALL have port iClkOrb, input, 1: orbit clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port iSwitch, input, 1: reader bank select; the write bank is ~iSwitch.
REQ-006 SHALL have ports iFastVal (input, 1), iFastData (input, 12) and oFastAck (output, 1): fast-channel handshake.
REQ-007 SHALL have ports iSlowVal (input, 1), iSlowData (input, 12) and oSlowAck (output, 1): slow-channel handshake.
REQ-008 SHALL have ports oWrAddr (output, 12) = {bank, idx[10:0]}, oWrData (output, 12) and oWrEn (output, 1): RAM write port.
REQ-009 SHALL have ports oFillDone (output, 1), oOverrun (output, 1, pulse) and oUnderrun (output, 1, sticky).

Function
REQ-010 SHALL register iSwitch into sw_d; toggle = iSwitch XOR sw_d.
REQ-011 SHALL implement FSM states IDLE, FILL and DONE.
REQ-012 SHALL, in IDLE or DONE on toggle: latch bank = ~iSwitch, clear idx, clear oFillDone and enter FILL.
REQ-013 SHALL assign slot ownership by idx[4:0]: 0-23 fast, 24-29 slow, 30-31 filler.
REQ-014 SHALL, in FILL when the owner's Val=1: assert that owner's Ack combinationally for exactly one cycle; the transfer occurs on that edge.
REQ-015 SHALL, on a transfer: register oWrEn=1, oWrData=owner data and oWrAddr={bank,idx} one cycle later (latency 1), then increment idx.
REQ-016 SHALL, on filler slots: write 12'h000 with no handshake, one word per cycle, and assert no Ack.
REQ-017 SHALL never assert the non-owner's Ack; fast and slow Ack are mutually exclusive.
REQ-018 SHALL count wait cycles in an owner slot while Val=0.
REQ-019 SHALL, when the wait count reaches TIMEOUT: write FILLER, set oUnderrun, advance idx and clear the wait count.
REQ-020 SHALL clear the wait count on every advance.
REQ-021 SHALL, after writing idx 2047: enter DONE with oFillDone=1, hold it until the next toggle, and issue no writes.
REQ-022 SHALL, on toggle while in FILL: pulse oOverrun for 1 cycle, abandon the remaining slots, and restart FILL on the new bank with idx=0.
REQ-023 SHALL apply toggle-restart before any handshake in the same cycle: no Ack that cycle.
REQ-024 SHALL wrap idx modulo 2048; the 11-bit idx never writes outside its bank.
REQ-025 SHALL clear oUnderrun only on reset or on entry to FILL.

Reset
REQ-026 SHALL, while reset=1: state=IDLE, sw_d=0, idx=0, wait=0, bank=0, and every output 0 (oWrAddr, oWrData, oWrEn, Acks, oFillDone, oOverrun, oUnderrun).
REQ-027 SHALL abort any fill on reset mid-operation with no further writes; after release, wait for a toggle.

Configuration
REQ-028 SHALL, with M16_FILL_CRC_EN defined: write idx 2047 as the 12-bit sum mod 4096 of all words written at idx 0-2046 of this fill, including filler and zero words.
REQ-029 SHALL, without M16_FILL_CRC_EN: write idx 2047 as 12'h000 like any other filler slot; no checksum logic is present.

Verification
REQ-030 SHALL cover basic fill: after reset, iSwitch 0->1, fast/slow Val held 1 with incrementing data -> 2048 writes to addresses 0x000-0x7FF; idx 30/31 slots write 0; oFillDone=1 after the last write.
REQ-031 SHALL cover priority: both Val=1 at idx 24 -> only oSlowAck=1; fast data is not consumed.
REQ-032 SHALL cover timeout: iSlowVal=0 at idx 24 -> after 63 wait cycles, 12'hFFF is written to {bank,24} and oUnderrun=1.
REQ-033 SHALL cover overrun: toggle at idx 1000 -> oOverrun pulses once; the next write goes to {new bank, 0}.
REQ-034 SHALL cover the checksum: with M16_FILL_CRC_EN and all source data 12'h001 -> idx 2047 = (1920 + 0) mod 4096 = 12'h780; without the macro, idx 2047 = 12'h000.
REQ-035 SHALL cover reset mid-fill: reset at idx 500 -> outputs 0 immediately, no writes until the next toggle.

Source files
------------

// File: rtl/m16_fill_sched.sv
// m16_fill_sched: fills one 2048-word RAM bank from fast/slow channels while the reader uses the other bank.
// Define M16_FILL_CRC_EN to store a running 12-bit sum of the fill in its last word.
module m16_fill_sched #(
  parameter int          TIMEOUT = 63,
  parameter logic [11:0] FILLER  = 12'hFFF
) (
  input  logic        iClkOrb,
  input  logic        reset,
  input  logic        iSwitch,
  input  logic        iFastVal,
  input  logic [11:0] iFastData,
  output logic        oFastAck,
  input  logic        iSlowVal,
  input  logic [11:0] iSlowData,
  output logic        oSlowAck,
  output logic [11:0] oWrAddr,
  output logic [11:0] oWrData,
  output logic        oWrEn,
  output logic        oFillDone,
  output logic        oOverrun,
  output logic        oUnderrun
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, stateNext;
  logic swD, bank, toggle, filling, slotFast, slotSlow, slotFill, hungry, timeout, advance, lastSlot;
  logic [10:0] idx;
  logic [WW-1:0] waitCnt;
  logic [11:0] wrWord, fillWord;
  assign toggle   = iSwitch ^ swD;
  assign filling  = (state == FILL) && !toggle;
  assign slotFast = idx[4:0] < 5'd24;
  assign slotSlow = !slotFast && (idx[4:0] < 5'd30);
  assign slotFill = idx[4:0] >= 5'd30;
  assign lastSlot = idx == 11'h7FF;
  assign oFastAck = filling && slotFast && iFastVal;
  assign oSlowAck = filling && slotSlow && iSlowVal;
  assign hungry   = filling && ((slotFast && !iFastVal) || (slotSlow && !iSlowVal));
  assign timeout  = hungry && (waitCnt == WW'(TIMEOUT - 1));
  assign advance  = oFastAck || oSlowAck || timeout || (filling && slotFill);
  assign wrWord   = oFastAck ? iFastData : oSlowAck ? iSlowData : timeout ? FILLER : fillWord;
`ifdef M16_FILL_CRC_EN
  logic [11:0] sum;
  always_ff @(posedge iClkOrb or posedge reset)
    if (reset) sum <= '0;
    else if (toggle) sum <= '0;
    else if (advance) sum <= sum + wrWord;
  assign fillWord = lastSlot ? sum : 12'h000;
`else
  assign fillWord = 12'h000;
`endif
  always_ff @(posedge iClkOrb or posedge reset)
    if (reset) state <= IDLE;
    else state <= stateNext;
  always_comb
    stateNext = toggle ? FILL : (advance && lastSlot) ? DONE : state;
  always_ff @(posedge iClkOrb or posedge reset)
    if (reset) begin
      swD       <= 1'b0;
      bank      <= 1'b0;
      idx       <= '0;
      waitCnt   <= '0;
      oWrEn     <= 1'b0;
      oWrAddr   <= '0;
      oWrData   <= '0;
      oFillDone <= 1'b0;
      oOverrun  <= 1'b0;
      oUnderrun <= 1'b0;
    end else begin
      swD      <= iSwitch;
      oWrEn    <= advance;
      oOverrun <= toggle && (state == FILL);
      if (toggle) begin
        bank      <= ~iSwitch;
        idx       <= '0;
        waitCnt   <= '0;
        oFillDone <= 1'b0;
        oUnderrun <= 1'b0;
      end else if (advance) begin
        oWrData <= wrWord;
        oWrAddr <= {bank, idx};
        idx     <= idx + 11'd1;
        waitCnt <= '0;
        if (timeout) oUnderrun <= 1'b1;
        if (lastSlot) oFillDone <= 1'b1;
      end else if (hungry) begin
        waitCnt <= waitCnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_m16_fill_sched.sv
// tb_m16_fill_sched: random and directed stimulus against a slot-level reference model of the fill scheduler.
module tb_m16_fill_sched;
  localparam int TIMEOUT = 63;
  localparam logic [11:0] FILLER = 12'hFFF;
`ifdef M16_FILL_CRC_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif
  logic iClkOrb = 1'b0, reset = 1'b1, iSwitch = 1'b0, iFastVal = 1'b0, iSlowVal = 1'b0;
  logic [11:0] iFastData = '0, iSlowData = '0;
  logic oFastAck, oSlowAck, oWrEn, oFillDone, oOverrun, oUnderrun;
  logic [11:0] oWrAddr, oWrData;
  m16_fill_sched dut (
    .iClkOrb(iClkOrb), .reset(reset), .iSwitch(iSwitch),
    .iFastVal(iFastVal), .iFastData(iFastData), .oFastAck(oFastAck),
    .iSlowVal(iSlowVal), .iSlowData(iSlowData), .oSlowAck(oSlowAck),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oWrEn(oWrEn),
    .oFillDone(oFillDone), .oOverrun(oOverrun), .oUnderrun(oUnderrun)
  );
  always #5 iClkOrb = ~iClkOrb;
  int errors = 0, checks = 0;
  int mIdx, mWait, mSum, eAddr, eData, wrCount, ovCount;
  bit mFill, mDone, mUnder, mBank, mSwD, curSw;
  logic [11:0] last2047;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic doReset();
    reset = 1'b1;
    iSwitch = 1'b0;
    curSw = 1'b0;
    #2;
    chk("rstFastAck", oFastAck, 0);
    chk("rstSlowAck", oSlowAck, 0);
    chk("rstWrEn", oWrEn, 0);
    chk("rstWrAddr", oWrAddr, 0);
    chk("rstWrData", oWrData, 0);
    chk("rstFillDone", oFillDone, 0);
    chk("rstOverrun", oOverrun, 0);
    chk("rstUnderrun", oUnderrun, 0);
    mIdx = 0; mWait = 0; mSum = 0; mFill = 0; mDone = 0; mUnder = 0; mBank = 0; mSwD = 0;
    @(posedge iClkOrb); #1;
    reset = 1'b0;
  endtask
  // One clock: drive inputs, check the combinational acks, advance the model, check registered outputs.
  task automatic cyc(input bit fv, input logic [11:0] fd, input bit sv, input logic [11:0] sd, input bit sw);
    bit tog, act, wr, eOver;
    int slot;
    logic [11:0] w;
    iFastVal = fv; iFastData = fd; iSlowVal = sv; iSlowData = sd; iSwitch = sw; curSw = sw;
    #2;
    tog = (sw != mSwD);
    act = mFill && !tog;
    slot = mIdx % 32;
    chk("fastAck", oFastAck, act && slot < 24 && fv);
    chk("slowAck", oSlowAck, act && slot >= 24 && slot < 30 && sv);
    wr = 0; eOver = 0; w = 12'h000;
    if (tog) begin
      eOver = mFill;
      mFill = 1; mDone = 0; mUnder = 0; mBank = !sw; mIdx = 0; mWait = 0; mSum = 0;
    end else if (mFill) begin
      if (slot >= 30) begin
        wr = 1;
        w = (CRC && mIdx == 2047) ? 12'(mSum) : 12'h000;
      end else if (slot < 24 ? fv : sv) begin
        wr = 1;
        w = slot < 24 ? fd : sd;
      end else if (mWait + 1 == TIMEOUT) begin
        wr = 1;
        w = FILLER;
        mUnder = 1;
      end else mWait++;
      if (wr) begin
        eAddr = mBank * 2048 + mIdx;
        eData = int'(w);
        mSum += int'(w);
        if (mIdx == 2047) begin mFill = 0; mDone = 1; end
        mIdx = (mIdx + 1) % 2048;
        mWait = 0;
      end
    end
    mSwD = sw;
    @(posedge iClkOrb); #1;
    chk("wrEn", oWrEn, wr);
    if (wr) begin
      chk("wrAddr", oWrAddr, eAddr);
      chk("wrData", oWrData, eData);
    end
    chk("fillDone", oFillDone, mDone);
    chk("overrun", oOverrun, eOver);
    chk("underrun", oUnderrun, mUnder);
    if (oWrEn) wrCount++;
    if (oOverrun) ovCount++;
    if (oWrEn && oWrAddr[10:0] == 11'h7FF) last2047 = oWrData;
  endtask
  initial begin
    doReset();
    wrCount = 0;
    for (int i = 0; i < 2060; i++) cyc(1'b1, 12'(i), 1'b1, 12'(i + 7), 1'b1);
    chk("basicWrites", wrCount, 2048);
    chk("basicDone", oFillDone, 1);
    wrCount = 0;
    for (int i = 0; i < 2060; i++) cyc(1'b1, 12'h001, 1'b1, 12'h001, 1'b0);
    chk("crcWrites", wrCount, 2048);
    chk("crc2047", last2047, CRC ? 12'h780 : 12'h000);
    for (int i = 0; i < 200; i++) cyc(1'b1, 12'($urandom), 1'b0, 12'($urandom), 1'b1);
    chk("timeoutUnderrun", oUnderrun, 1);
    for (int i = 0; i < 3000; i++) begin
      bit sw;
      sw = ($urandom_range(0, 799) == 0) ? !curSw : curSw;
      cyc($urandom_range(0, 3) != 0, 12'($urandom), $urandom_range(0, 3) != 0, 12'($urandom), sw);
    end
    cyc(1'b1, 12'h055, 1'b1, 12'h0AA, !curSw);
    ovCount = 0;
    for (int k = 0; k < 1200 && mIdx != 1000; k++) cyc(1'b1, 12'($urandom), 1'b1, 12'($urandom), curSw);
    cyc(1'b1, 12'h123, 1'b1, 12'h456, !curSw);
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'($urandom), 1'b1, 12'($urandom), curSw);
    chk("overrunPulses", ovCount, 1);
    cyc(1'b1, 12'h011, 1'b1, 12'h022, !curSw);
    for (int k = 0; k < 700 && mIdx != 500; k++) cyc(1'b1, 12'($urandom), 1'b1, 12'($urandom), curSw);
    doReset();
    wrCount = 0;
    for (int i = 0; i < 40; i++) cyc(1'b1, 12'($urandom), 1'b1, 12'($urandom), 1'b0);
    chk("noWritesAfterReset", wrCount, 0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 12'($urandom), $urandom_range(0, 1) == 1, 12'($urandom), 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
